lsu_waitstate: RTL

Parametrised load/store unit with an embedded data RAM, sitting between the core's execute stage and writeback. It extends the single-cycle 32-bit data memory path to configurable data width, configurable access latency (wait states), full RV32/RV64 byte/half/word(/double) sizing with sign/zero extension, and misalignment detection. It uses a valid/ready request and a one-cycle response pulse so the core can stall. The same `wr`/`rd`/`addr`/`wr_data`/`rd_data` observation outputs as the core top are kept for the testbench.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 72 +++++++
 rtl/lsu_waitstate.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and helpers for the wait-state load/store unit.
//   lsu_state_e  : FSM state encoding (IDLE, WAIT, RESP)
//   F3_*         : RISC-V load/store funct3 size/sign encodings
//   size_bytes() : access size in bytes for a funct3 (0 = undefined encoding)
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] sz;
    case (funct3)
      F3_B, F3_BU: sz = 4'd1;
      F3_H, F3_HU: sz = 4'd2;
      F3_W, F3_WU: sz = 4'd4;
      F3_D:        sz = 4'd8;
      default:     sz = 4'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for the load/store unit.
//   i_size     : access size in bytes (0 = undefined funct3)
//   i_signed   : 1 for sign-extending loads (B/H/W/D), 0 for U variants
//   i_we       : 1 = store, 0 = load
//   i_offset   : byte offset of the access inside the RAM word
//   i_old_word : current RAM word at the addressed index
//   i_wdata    : right-aligned store data
//   o_merged   : RAM word with only the addressed lanes replaced by store data
//   o_load     : lane-shifted and sign/zero-extended load result
//   o_err      : misaligned access or illegal size/sign/direction combination
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]                    i_size,
  input  logic                          i_signed,
  input  logic                          i_we,
  input  logic [$clog2(DATA_W/8)-1:0]   i_offset,
  input  logic [DATA_W-1:0]             i_old_word,
  input  logic [DATA_W-1:0]             i_wdata,
  output logic [DATA_W-1:0]             o_merged,
  output logic [DATA_W-1:0]             o_load,
  output logic                          o_err
);

  localparam int unsigned NB = DATA_W / 8;

  logic [31:0]       w_sz;
  logic [31:0]       w_off;
  logic [DATA_W-1:0] w_wshift;
  logic [DATA_W-1:0] w_rshift;
  logic              w_msb;

  always_comb begin
    w_sz     = 32'(i_size);
    w_off    = 32'(i_offset);
    w_wshift = i_wdata << (w_off * 8);
    w_rshift = i_old_word >> (w_off * 8);

    o_merged = i_old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((i >= w_off) && (i < (w_off + w_sz))) begin
        o_merged[i*8 +: 8] = w_wshift[i*8 +: 8];
      end
    end

    case (i_size)
      4'd1:    w_msb = w_rshift[7];
      4'd2:    w_msb = w_rshift[15];
      4'd4:    w_msb = w_rshift[31];
      default: w_msb = w_rshift[DATA_W-1];
    endcase

    o_load = '0;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      o_load[b] = (b < (w_sz * 8)) ? w_rshift[b] : (i_signed & w_msb);
    end

    // Unsigned variants are load-only and must be narrower than the word
    // (WU only exists when the word is 64 bits wide).
    o_err = 1'b0;
    if ((w_sz == 32'd0) || (w_sz > NB)) begin
      o_err = 1'b1;
    end else if (!i_signed && (i_we || (w_sz >= NB))) begin
      o_err = 1'b1;
    end else if ((w_off & (w_sz - 32'd1)) != 32'd0) begin
      o_err = 1'b1;
    end
  end

endmodule

// File: rtl/lsu_waitstate.sv
// lsu_waitstate: load/store unit with embedded data RAM and configurable wait states.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready : request handshake; req_ready depends on state only
//   req_we, req_funct3  : store/load select and RISC-V size/sign encoding
//   req_addr, req_wdata : byte address and right-aligned store data
//   resp_valid          : one-cycle response pulse
//   resp_rdata/resp_err : extended load data (0 for stores/errors), error flag
//   wr, rd              : store committed / load completed (high during response)
//   addr                : latched request address
//   wr_data, rd_data    : last merged word written / last load result
module lsu_waitstate
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned OFF_W    = $clog2(NB);
  localparam int unsigned IDX_W    = ADDR_W - OFF_W;
  localparam int unsigned DEPTH    = 1 << IDX_W;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  lsu_state_e        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_wr;
  logic              r_rd;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_sel_we;
  logic [2:0]        w_sel_funct3;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic [3:0]        w_size;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_load;
  logic              w_err;
  logic              w_do_store;
  logic              w_do_load;

  // With zero wait states the access completes on the accept edge itself,
  // before the request latch holds it, so in IDLE the live request drives
  // the datapath; in every later state the latched copy does.
  always_comb begin
    if (r_state == IDLE) begin
      w_sel_we     = req_we;
      w_sel_funct3 = req_funct3;
      w_sel_addr   = req_addr;
      w_sel_wdata  = req_wdata;
    end else begin
      w_sel_we     = r_we;
      w_sel_funct3 = r_funct3;
      w_sel_addr   = r_addr;
      w_sel_wdata  = r_wdata;
    end
  end

  assign w_idx  = w_sel_addr[ADDR_W-1:OFF_W];
  assign w_off  = w_sel_addr[OFF_W-1:0];
  assign w_size = size_bytes(w_sel_funct3);
  assign w_old  = r_mem[w_idx];

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_size     (w_size),
    .i_signed   (~w_sel_funct3[2]),
    .i_we       (w_sel_we),
    .i_offset   (w_off),
    .i_old_word (w_old),
    .i_wdata    (w_sel_wdata),
    .o_merged   (w_merged),
    .o_load     (w_load),
    .o_err      (w_err)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_do_store = w_enter_resp &  w_sel_we & ~w_err;
  assign w_do_load  = w_enter_resp & ~w_sel_we & ~w_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_wr_data    <= '0;
      r_rd_data    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      r_wr       <= w_do_store;
      r_rd       <= w_do_load;
      r_resp_err <= w_enter_resp & w_err;
      if (w_enter_resp) begin
        r_resp_rdata <= w_do_load ? w_load : '0;
      end
      if (w_do_store) begin
        r_wr_data <= w_merged;
      end
      if (w_do_load) begin
        r_rd_data <= w_load;
      end
    end
  end

  // RAM contents survive reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && w_do_store) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign wr         = r_wr;
  assign rd         = r_rd;
  assign addr       = r_addr;
  assign wr_data    = r_wr_data;
  assign rd_data    = r_rd_data;

endmodule
